paula_floppy_mfm_deser: RTL

Serial-to-parallel front end of the Paula floppy read path. It takes one MFM bit per strobe from the drive model and assembles 16-bit words. Optionally it waits for and aligns to the DSKSYNC word. It writes exactly DSKLEN words into the downstream 2048x16 floppy FIFO and raises sync and done events for the interrupt logic.

---
 rtl/paula_floppy_pkg.sv | 12 +
 rtl/paula_floppy_shifter.sv | 43 ++++
 rtl/paula_floppy_mfm_deser.sv | 105 ++++++++++
 3 files changed

// File: rtl/paula_floppy_pkg.sv
// rtl/paula_floppy_pkg.sv - shared constants and FSM encoding for the floppy read path
package paula_floppy_pkg;

  localparam int LEN_W      = 14;
  localparam int FIFO_DEPTH = 2048;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_SYNC = 2'd1;
  localparam state_t ST_XFER      = 2'd2;

endpackage

// File: rtl/paula_floppy_shifter.sv
// rtl/paula_floppy_shifter.sv - MFM bit shifter, word bit counter and DSKSYNC comparator
module paula_floppy_shifter
  import paula_floppy_pkg::*;
(
  input  logic        clk,
  input  logic        clk7_en,
  input  logic        reset,
  input  logic        bit_stb,
  input  logic        bit_in,
  input  logic [15:0] dsksync,
  input  logic        wordsync,
  input  logic        cnt_clr,
  output logic [15:0] sreg_next,
  output logic [3:0]  bitcnt,
  output logic        match
);

  logic [15:0] sreg;

  // Compare against the value the register is about to take so a match
  // is seen on the same strobe that delivers the final sync bit.
  assign sreg_next = {sreg[14:0], bit_in};
  assign match     = bit_stb && (sreg_next == dsksync);

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        sreg   <= 16'd0;
        bitcnt <= 4'd0;
      end else begin
        if (bit_stb) begin
          sreg <= sreg_next;
        end
        if (cnt_clr || (wordsync && match)) begin
          bitcnt <= 4'd0;
        end else if (bit_stb) begin
          bitcnt <= bitcnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/paula_floppy_mfm_deser.sv
// rtl/paula_floppy_mfm_deser.sv - MFM serial-to-parallel deserializer feeding the floppy FIFO
module paula_floppy_mfm_deser
  import paula_floppy_pkg::*;
#(
  parameter int LEN_W = paula_floppy_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             clk7_en,
  input  logic             reset,
  input  logic             bit_stb,
  input  logic             bit_in,
  input  logic [15:0]      dsksync,
  input  logic             wordsync,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [15:0]      fifo_data,
  output logic             sync_det,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [15:0]      sreg_next;
  logic [3:0]       bitcnt;
  logic             match;
  logic             start_ok;
  logic             cnt_clr;
  logic             word_evt;

  // A zero-length start is ignored in every state.
  assign start_ok = start && (len != '0);
  assign cnt_clr  = start_ok || ((state == ST_WAIT_SYNC) && match);
  // Boundary and realign coinciding still yield exactly one word.
  assign word_evt = bit_stb && ((bitcnt == 4'd15) || (wordsync && match));
  assign busy     = (state != ST_IDLE);

  paula_floppy_shifter u_shifter (
    .clk       (clk),
    .clk7_en   (clk7_en),
    .reset     (reset),
    .bit_stb   (bit_stb),
    .bit_in    (bit_in),
    .dsksync   (dsksync),
    .wordsync  (wordsync),
    .cnt_clr   (cnt_clr),
    .sreg_next (sreg_next),
    .bitcnt    (bitcnt),
    .match     (match)
  );

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        state     <= ST_IDLE;
        remaining <= '0;
        fifo_wr   <= 1'b0;
        fifo_data <= 16'd0;
        sync_det  <= 1'b0;
        done      <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        fifo_wr  <= 1'b0;
        done     <= 1'b0;
        sync_det <= match;
        if (start_ok) begin
          remaining <= len;
          overflow  <= 1'b0;
          state     <= wordsync ? ST_WAIT_SYNC : ST_XFER;
        end else begin
          case (state)
            ST_IDLE: ;
            ST_WAIT_SYNC: begin
              if (match) begin
                state <= ST_XFER;
              end
            end
            ST_XFER: begin
              if (word_evt) begin
                if (!fifo_full) begin
                  fifo_wr   <= 1'b1;
                  fifo_data <= sreg_next;
                end else begin
                  overflow <= 1'b1;
                end
                if (remaining != '0) begin
                  remaining <= remaining - LEN_W'(1);
                end
                if (remaining == LEN_W'(1)) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
